dom_rr_sched: RTL and testbench

DOM_RR_SCHED -- requirements
Module: dom_rr_sched

---
 rtl/dom_sched_pkg.sv | 6 +
 rtl/dom_and_d1.sv | 22 ++
 rtl/dom_rr_sched.sv | 73 +++++++
 tb/tb_dom_rr_sched.sv | 119 +++++++++++
 4 files changed

// File: rtl/dom_sched_pkg.sv
// dom_sched_pkg: shared FSM states and LFSR constants for the DOM round-robin scheduler
package dom_sched_pkg;
  typedef enum logic [1:0] {IDLE, COMP, OUT} state_t;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_ZERO_SEED = 16'h0001;
endpackage

// File: rtl/dom_and_d1.sv
// dom_and_d1: first-order DOM AND gadget with registered, refreshed cross-domain terms
module dom_and_d1 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       r,
  output logic [1:0] c
);
  logic a0b0, a1b1, a0b1, a1b0;
  logic [1:0] q;
  assign a0b0 = a[0] & b[0];
  assign a1b1 = a[1] & b[1];
  assign a0b1 = a[0] & b[1];
  assign a1b0 = a[1] & b[0];
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else if (en) q <= {a1b0 ^ r, a0b1 ^ r};
  end
  assign c = {a1b1 ^ q[1], a0b0 ^ q[0]};
endmodule

// File: rtl/dom_rr_sched.sv
// dom_rr_sched: round-robin sharing of one DOM AND gadget among N_REQ requesters
module dom_rr_sched
  import dom_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LFSR_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LFSR_W-1:0]          port_seed,
  input  logic [N_REQ-1:0]           req,
  input  logic [2*N_REQ-1:0]         port_a,
  input  logic [2*N_REQ-1:0]         port_b,
  output logic [N_REQ-1:0]           gnt,
  output logic                       valid,
  output logic [1:0]                 port_c,
  output logic [$clog2(N_REQ)-1:0]   port_id
);
  localparam int IW = $clog2(N_REQ);
  state_t state;
  logic [IW-1:0] last_grant, win, idx, op_id;
  logic [1:0] op_a, op_b, gc;
  logic [LFSR_W-1:0] lfsr;
  logic found, accept;
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = IW'((int'(last_grant) + i) % N_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  assign accept = !rst && state != COMP && found;
  assign gnt = accept ? (N_REQ'(1) << win) : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= IW'(N_REQ - 1);
      op_a <= '0;
      op_b <= '0;
      op_id <= '0;
      valid <= 1'b0;
      lfsr <= (port_seed == '0) ? LFSR_W'(LFSR_ZERO_SEED) : port_seed;
    end else begin
      valid <= state == COMP;
      if (accept) begin
        state <= COMP;
        last_grant <= win;
        op_id <= win;
        op_a <= port_a[{win, 1'b0} +: 2];
        op_b <= port_b[{win, 1'b0} +: 2];
        lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_W'(LFSR_TAPS))};
      end else begin
        state <= (state == COMP) ? OUT : IDLE;
      end
    end
  end
  dom_and_d1 u_gadget (
    .clk(clk),
    .rst(rst),
    .en (state == COMP),
    .a  (op_a),
    .b  (op_b),
    .r  (lfsr[0]),
    .c  (gc)
  );
  assign port_c = valid ? gc : 2'b00;
  assign port_id = valid ? op_id : '0;
endmodule

// File: tb/tb_dom_rr_sched.sv
// tb_dom_rr_sched: directed and random stimulus checked against a behavioural scheduler model
module tb_dom_rr_sched;
  logic clk = 1'b0;
  logic rst;
  logic [15:0] port_seed;
  logic [3:0] req, gnt;
  logic [7:0] port_a, port_b;
  logic valid;
  logic [1:0] port_c, port_id;
  int n_tests = 0, n_fail = 0;
  int m_phase, m_last, m_id;
  logic [15:0] m_lfsr;
  logic [1:0] m_a, m_b;
  logic m_r;

  dom_rr_sched #(.N_REQ(4), .LFSR_W(16)) dut (
    .clk(clk), .rst(rst), .port_seed(port_seed), .req(req), .port_a(port_a),
    .port_b(port_b), .gnt(gnt), .valid(valid), .port_c(port_c), .port_id(port_id)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic int pick(input logic [3:0] rq);
    for (int i = 1; i <= 4; i++) if (rq[(m_last + i) % 4]) return (m_last + i) % 4;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic [3:0] rq, input logic [7:0] a, input logic [7:0] b,
                       input logic r_in, input logic [15:0] sd);
    int w;
    logic ev;
    logic [1:0] ec;
    rst = r_in; req = rq; port_a = a; port_b = b; port_seed = sd;
    #2;
    w = (r_in || m_phase == 1) ? -1 : pick(rq);
    chk("gnt", {12'b0, gnt}, (w < 0) ? 16'h0 : 16'(1 << w));
    @(posedge clk);
    if (r_in) begin
      m_phase = 0; m_last = 3; m_lfsr = (sd == 16'h0) ? 16'h0001 : sd;
    end else if (w >= 0) begin
      m_phase = 1; m_last = w; m_id = w;
      m_a = a[2*w +: 2]; m_b = b[2*w +: 2];
      m_lfsr = step(m_lfsr);
    end else if (m_phase == 1) begin
      m_phase = 2; m_r = m_lfsr[0];
    end else m_phase = 0;
    #1;
    ev = (m_phase == 2);
    ec = ev ? {(m_a[1] & m_b[1]) ^ (m_a[1] & m_b[0]) ^ m_r,
               (m_a[0] & m_b[0]) ^ (m_a[0] & m_b[1]) ^ m_r} : 2'b00;
    chk("valid", {15'b0, valid}, {15'b0, ev});
    chk("port_c", {14'b0, port_c}, {14'b0, ec});
    chk("port_id", {14'b0, port_id}, ev ? 16'(m_id) : 16'h0);
    if (ev) chk("product", {15'b0, port_c[0] ^ port_c[1]},
                {15'b0, (m_a[0] ^ m_a[1]) & (m_b[0] ^ m_b[1])});
  endtask

  initial begin
    m_phase = 0; m_last = 3; m_id = 0; m_lfsr = 16'h0001; m_a = 0; m_b = 0; m_r = 0;
    // single op with seed ACE1
    cycle(4'hF, 8'h00, 8'h00, 1'b1, 16'hACE1);
    cycle(4'hF, 8'h00, 8'h00, 1'b1, 16'hACE1);
    cycle(4'b0001, 8'h01, 8'h03, 1'b0, 16'h0);
    cycle(4'b0000, 8'h00, 8'h00, 1'b0, 16'h0);
    chk("single_op_c", {14'b0, port_c}, 16'h3);
    chk("single_op_id", {14'b0, port_id}, 16'h0);
    cycle(4'b0000, 8'h00, 8'h00, 1'b0, 16'h0);
    // contention: all requesters held
    cycle(4'b0000, 8'h00, 8'h00, 1'b1, 16'h1234);
    for (int i = 0; i < 12; i++) cycle(4'hF, 8'($urandom), 8'($urandom), 1'b0, 16'h0);
    cycle(4'b0000, 8'h00, 8'h00, 1'b0, 16'h0);
    cycle(4'b0000, 8'h00, 8'h00, 1'b0, 16'h0);
    // exhaustive shares on requester 2
    for (int v = 0; v < 256; v++) begin
      cycle(4'b0100, {v[7:6], v[1:0], v[5:2]}, {v[5:4], v[3:2], v[7:6], v[1:0]}, 1'b0, 16'h0);
      cycle(4'b0000, 8'h00, 8'h00, 1'b0, 16'h0);
      cycle(4'b0000, 8'h00, 8'h00, 1'b0, 16'h0);
    end
    // zero seed substitutes 16'h0001
    cycle(4'b0000, 8'h00, 8'h00, 1'b1, 16'h0000);
    cycle(4'b1000, 8'h40, 8'h80, 1'b0, 16'h0);
    cycle(4'b0000, 8'h00, 8'h00, 1'b0, 16'h0);
    chk("zero_seed_c", {14'b0, port_c}, 16'h1);
    cycle(4'b0000, 8'h00, 8'h00, 1'b0, 16'h0);
    for (int i = 0; i < 2000; i++) cycle(4'($urandom) | 4'b0001, 8'($urandom), 8'($urandom), 1'b0, 16'h0);
    // reset during COMP aborts
    cycle(4'b0000, 8'h00, 8'h00, 1'b0, 16'h0);
    cycle(4'b0000, 8'h00, 8'h00, 1'b0, 16'h0);
    cycle(4'b0010, 8'hFF, 8'hFF, 1'b0, 16'h0);
    cycle(4'b1111, 8'hFF, 8'hFF, 1'b1, 16'h5A5A);
    chk("abort_valid", {15'b0, valid}, 16'h0);
    for (int i = 0; i < 3; i++) cycle(4'b0000, 8'h00, 8'h00, 1'b0, 16'h0);
    // withdrawn request during COMP
    cycle(4'b0001, 8'h03, 8'h01, 1'b0, 16'h0);
    cycle(4'b0010, 8'h0C, 8'h0C, 1'b0, 16'h0);
    cycle(4'b0000, 8'h00, 8'h00, 1'b0, 16'h0);
    cycle(4'b0000, 8'h00, 8'h00, 1'b0, 16'h0);
    cycle(4'b0001, 8'h02, 8'h03, 1'b0, 16'h0);
    cycle(4'b0000, 8'h00, 8'h00, 1'b0, 16'h0);
    cycle(4'b0000, 8'h00, 8'h00, 1'b0, 16'h0);
    // random traffic with occasional resets
    for (int i = 0; i < 600; i++)
      cycle(4'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(63) == 0), 16'($urandom));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
